// File: rtl/memory_bank_arbiter.sv
// rtl/memory_bank_arbiter.sv - single-bank responder granting exclusive valid/rdy access to one of NUM_PORTS initiators
// Optional feature macro: MEM_BANK_ROUND_ROBIN_EN (round-robin arbitration; fixed lowest-index priority when undefined).
module memory_bank_arbiter #(
    parameter int BITS              = 16,
    parameter int ADDRESS_BITS      = 15,
    parameter int BANK_ADDRESS_BITS = 14,
    parameter int NUM_PORTS         = 3
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NUM_PORTS-1:0]                  valid,
    input  logic [NUM_PORTS*(ADDRESS_BITS+1)-1:0] address,
    input  logic [NUM_PORTS*BITS-1:0]             wr_data,
    input  logic [NUM_PORTS*2-1:0]                wr_mask,
    input  logic [NUM_PORTS-1:0]                  mem_wr,
    output logic [NUM_PORTS-1:0]                  rdy,
    output logic [BITS-1:0]                       rd_data,
    output logic [2:0]                            owner
);

    localparam int AW    = ADDRESS_BITS + 1;
    localparam int LANE  = BITS / 2;
    localparam int DEPTH = 1 << BANK_ADDRESS_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             owner_q, owner_d;
    logic [NUM_PORTS-1:0]   rdy_q, rdy_d;
    logic [BITS-1:0]        rd_data_q;
    logic [BITS-1:0]        mem_q [DEPTH];

    // Fields of the currently owning port
    logic                         own_valid;
    logic                         own_wr;
    logic [1:0]                   own_mask;
    logic [BANK_ADDRESS_BITS-1:0] own_addr;
    logic [BITS-1:0]              own_data;

    logic       access;
    logic       any_valid;
    logic [2:0] winner;

    // Address bits above the bank index are decoded upstream and deliberately ignored here
    logic unused_addr_bits;
    assign unused_addr_bits = ^address;

    // Select the owner's request fields out of the packed port buses
    always_comb begin
        own_valid = 1'b0;
        own_wr    = 1'b0;
        own_mask  = 2'b00;
        own_addr  = '0;
        own_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (owner_q == 3'(i)) begin
                own_valid = valid[i];
                own_wr    = mem_wr[i];
                own_mask  = wr_mask[2*i +: 2];
                own_addr  = address[AW*i +: BANK_ADDRESS_BITS];
                own_data  = wr_data[BITS*i +: BITS];
            end
        end
    end

`ifdef MEM_BANK_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic       rr_found;

    // Round-robin pick: first requesting port at or after the pointer, wrapping once
    always_comb begin
        any_valid = |valid;
        winner    = '0;
        rr_found  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!rr_found && valid[i] &&
                    ((int'(rr_ptr_q) + k == i) || (int'(rr_ptr_q) + k == i + NUM_PORTS))) begin
                    rr_found = 1'b1;
                    winner   = 3'(i);
                end
            end
        end
    end

    // Pointer moves past the port just granted so it goes to the back of the line
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE && any_valid) begin
            rr_ptr_d = (winner == 3'(NUM_PORTS - 1)) ? 3'd0 : winner + 3'd1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest requesting index wins
    always_comb begin
        any_valid = |valid;
        winner    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid[i]) begin
                winner = 3'(i);
            end
        end
    end
`endif

    // Grant FSM: hold the owner until it drops valid, then one dead cycle before re-arbitrating
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        access  = 1'b0;
        rdy_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_GRANT;
                    owner_d = winner;
                end
            end
            ST_GRANT: begin
                if (own_valid) begin
                    access = 1'b1;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            rdy_d[i] = (state_d == ST_GRANT) && (owner_d == 3'(i));
        end
    end

    // Control state and read data; read sees the word before any same-edge write
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rdy_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rdy_q   <= rdy_d;
            if (access) begin
                rd_data_q <= mem_q[own_addr];
            end
        end
    end

    // Byte-lane writes by the owner; a write coinciding with reset is dropped
    always_ff @(posedge CLK) begin
        if (!RST && access && own_wr) begin
            if (own_mask[0]) begin
                mem_q[own_addr][LANE-1:0] <= own_data[LANE-1:0];
            end
            if (own_mask[1]) begin
                mem_q[own_addr][BITS-1:LANE] <= own_data[BITS-1:LANE];
            end
        end
    end

    assign rdy     = rdy_q;
    assign rd_data = rd_data_q;
    assign owner   = owner_q;

endmodule
